// File: rtl/mul_prec_scheduler.sv
// Issue scheduler for a multi-precision multiplier: round-robin arbitration with a
// completion table that prevents two operations from exiting in the same cycle.
module mul_prec_scheduler #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LAT4  = 2,
    parameter int unsigned LAT8  = 3,
    parameter int unsigned LAT16 = 5,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*2-1:0]       req_prec,
    output logic                    mul_in_valid,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_out4_valid,
    input  logic [7:0]              mul_p4,
    input  logic                    mul_out8_valid,
    input  logic [15:0]             mul_p8,
    input  logic                    mul_out16_valid,
    input  logic [31:0]             mul_p16,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [1:0]              rsp_prec,
    output logic [31:0]             rsp_data,
    output logic                    busy,
    output logic [31:0]             perf_issue_cnt,
    output logic [31:0]             perf_conflict_cnt
);

    function automatic int unsigned lat_of(input logic [1:0] p);
        case (p)
            2'd0:    return LAT4;
            2'd1:    return LAT8;
            default: return LAT16;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] zext_op(input logic [WIDTH-1:0] x, input logic [1:0] p);
        case (p)
            2'd0:    return WIDTH'(x[3:0]);
            2'd1:    return WIDTH'(x[7:0]);
            default: return x;
        endcase
    endfunction

    // Table slot k holds the operation that exits the multiplier k cycles from now.
    function automatic logic slot_busy(input logic [LAT16-1:0] v, input int unsigned l);
        slot_busy = 1'b0;
        for (int unsigned k = 0; k < LAT16; k++) begin
            if (v[k] && k == l) slot_busy = 1'b1;
        end
    endfunction

    logic [IDW-1:0]   ptr_q;
    logic [LAT16-1:0] tbl_vld_q, tbl_vld_d;
    logic [IDW-1:0]   tbl_id_q   [LAT16];
    logic [IDW-1:0]   tbl_id_d   [LAT16];
    logic [1:0]       tbl_prec_q [LAT16];
    logic [1:0]       tbl_prec_d [LAT16];
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [1:0]       rsp_prec_q;
    logic [31:0]      rsp_data_q;
    logic [31:0]      issue_cnt_q, conflict_cnt_q;

    logic [NREQ-1:0]  eligible, grant;
    logic [IDW-1:0]   gnt_idx;
    logic             found, issue;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [1:0]       sel_prec;
    logic [31:0]      cmp_data;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && !slot_busy(tbl_vld_q, lat_of(req_prec[i*2 +: 2]));
        end
    end

    // Scan from the pointer, granting the first eligible requester.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && !rst && eligible[i] && i == (32'(ptr_q) + k) % NREQ) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_prec = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
                sel_prec = req_prec[i*2 +: 2];
            end
        end
    end

    assign issue        = |grant;
    assign req_ready    = grant;
    assign mul_in_valid = issue;
    assign mul_a        = zext_op(sel_a, sel_prec);
    assign mul_b        = zext_op(sel_b, sel_prec);

    always_comb begin
        for (int unsigned k = 0; k < LAT16 - 1; k++) begin
            tbl_vld_d[k]  = tbl_vld_q[k+1];
            tbl_id_d[k]   = tbl_id_q[k+1];
            tbl_prec_d[k] = tbl_prec_q[k+1];
        end
        tbl_vld_d[LAT16-1]  = 1'b0;
        tbl_id_d[LAT16-1]   = '0;
        tbl_prec_d[LAT16-1] = '0;
        for (int unsigned k = 0; k < LAT16; k++) begin
            if (issue && k + 1 == lat_of(sel_prec)) begin
                tbl_vld_d[k]  = 1'b1;
                tbl_id_d[k]   = gnt_idx;
                tbl_prec_d[k] = sel_prec[1] ? 2'd2 : sel_prec;
            end
        end
    end

    // A missing exit valid still retires the entry, with zero data.
    always_comb begin
        case (tbl_prec_q[0])
            2'd0:    cmp_data = mul_out4_valid  ? 32'(mul_p4) : '0;
            2'd1:    cmp_data = mul_out8_valid  ? 32'(mul_p8) : '0;
            default: cmp_data = mul_out16_valid ? mul_p16     : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= '0;
            tbl_vld_q      <= '0;
            for (int unsigned k = 0; k < LAT16; k++) begin
                tbl_id_q[k]   <= '0;
                tbl_prec_q[k] <= '0;
            end
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_prec_q     <= '0;
            rsp_data_q     <= '0;
            issue_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            tbl_vld_q <= tbl_vld_d;
            for (int unsigned k = 0; k < LAT16; k++) begin
                tbl_id_q[k]   <= tbl_id_d[k];
                tbl_prec_q[k] <= tbl_prec_d[k];
            end
            if (issue) begin
                ptr_q       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end else if (|req_valid) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            rsp_valid_q <= tbl_vld_q[0];
            rsp_id_q    <= tbl_vld_q[0] ? tbl_id_q[0]   : '0;
            rsp_prec_q  <= tbl_vld_q[0] ? tbl_prec_q[0] : '0;
            rsp_data_q  <= tbl_vld_q[0] ? cmp_data      : '0;
        end
    end

    assign rsp_valid         = rsp_valid_q && !rst;
    assign rsp_id            = rst ? '0 : rsp_id_q;
    assign rsp_prec          = rst ? '0 : rsp_prec_q;
    assign rsp_data          = rst ? '0 : rsp_data_q;
    assign busy              = !rst && ((|tbl_vld_q) || rsp_valid_q);
    assign perf_issue_cnt    = rst ? '0 : issue_cnt_q;
    assign perf_conflict_cnt = rst ? '0 : conflict_cnt_q;

endmodule
